// File: rtl/timer_arbiter.sv
// Two-requester round-robin arbiter with a shared down-counter.
// The winner holds the grant for L+1 RUN cycles, then gets a one-cycle done pulse.
module timer_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] len0_i,
    input  logic [WIDTH-1:0] len1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic [WIDTH-1:0] cnt_q;
    logic             prio_q;
    logic             win_q;

    logic             win_d;
    logic [WIDTH-1:0] len_d;
    logic             own_req;

    // A lone requester wins outright; prio_q only breaks a tie.
    always_comb begin
        win_d = prio_q;
        case (req_i)
            2'b01:   win_d = 1'b0;
            2'b10:   win_d = 1'b1;
            default: win_d = prio_q;
        endcase
        len_d   = win_d ? len1_i : len0_i;
        own_req = win_q ? req_i[1] : req_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 2'b00;
                    if (req_i != 2'b00) begin
                        state_q <= S_RUN;
                        win_q   <= win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        cnt_q   <= len_d;
                    end
                end
                S_RUN: begin
                    // Reaching zero wins over a same-edge request drop, so done is never lost.
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= win_q ? 2'b10 : 2'b01;
                    end else if (!own_req) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 2'b00;
                        cnt_q   <= '0;
                        prio_q  <= ~win_q;
                    end else begin
                        cnt_q <= cnt_q - WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    prio_q  <= ~win_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign cnt_o  = cnt_q;
    assign busy_o = (state_q != S_IDLE);

endmodule
